// File: rtl/host_byte_bridge.sv
// Byte-stream host front end for wishbone_master: parses request frames into o_ready words, serializes out_en words; TX strobes gated by i_tx_busy, one per 2 cycles.
// Optional HOST_BYTE_BRIDGE_ECHO_EN: each pending command word is echoed as a 5-byte TX frame before o_ready is issued.
module host_byte_bridge #(
  parameter logic [31:0] RX_TIMEOUT = 32'd100000,
  parameter logic [7:0]  SYNC_RX    = 8'hCD,
  parameter logic [7:0]  SYNC_TX    = 8'hDC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_stb,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_stb,
  input  logic        i_tx_busy,
  input  logic        i_master_ready,
  output logic        o_ready,
  output logic [31:0] o_command,
  output logic [31:0] o_address,
  output logic [31:0] o_data,
  output logic [27:0] o_data_count,
  output logic        o_ih_reset,
  input  logic        i_en,
  input  logic [31:0] i_status,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data,
  input  logic [27:0] i_data_count,
  output logic        o_out_ready,
  output logic        o_rx_overflow
);

`ifdef HOST_BYTE_BRIDGE_ECHO_EN
  localparam bit ECHO_EN = 1'b1;
`else
  localparam bit ECHO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {RX_IDLE, RX_HDR, RX_DATA, RX_PEND, RX_RST} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  rx_state_t    rx_state;
  tx_state_t    tx_state;
  logic [3:0]   byte_cnt;
  logic [83:0]  hdr_sr;
  logic [91:0]  hdr_full;
  logic [23:0]  data_sr;
  logic [27:0]  words_left;
  logic [31:0]  idle_cnt;
  logic         rx_timeout;
  logic         echo_req;
  logic         echo_ok;
  logic         echo_done;
  logic [135:0] tx_sr;
  logic [4:0]   tx_left;
  logic         tx_gap;
  logic         tx_is_echo;

  // The oldest nibble of data_count falls off the shift register, which discards bits [31:28].
  assign hdr_full   = {hdr_sr, i_rx_byte};
  assign rx_timeout = !i_rx_stb && (idle_cnt >= RX_TIMEOUT - 32'd1);
  assign echo_req   = ECHO_EN && (rx_state == RX_PEND) && !echo_done;
  assign echo_ok    = !ECHO_EN || echo_done;

  // Strobe is combinational so it can never coincide with a busy cycle.
  assign o_tx_stb  = (tx_state == TX_SEND) && !i_tx_busy && !tx_gap;
  assign o_tx_byte = tx_sr[135:128];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state      <= RX_IDLE;
      byte_cnt      <= '0;
      hdr_sr        <= '0;
      data_sr       <= '0;
      words_left    <= '0;
      idle_cnt      <= '0;
      o_ready       <= 1'b0;
      o_ih_reset    <= 1'b0;
      o_rx_overflow <= 1'b0;
      o_command     <= '0;
      o_address     <= '0;
      o_data        <= '0;
      o_data_count  <= '0;
    end else begin
      o_ready    <= 1'b0;
      o_ih_reset <= 1'b0;
      if (i_rx_stb)
        idle_cnt <= '0;
      else if (idle_cnt != '1)
        idle_cnt <= idle_cnt + 32'd1;
      case (rx_state)
        RX_IDLE: begin
          idle_cnt <= '0;
          if (i_rx_stb && i_rx_byte == SYNC_RX) begin
            rx_state <= RX_HDR;
            byte_cnt <= '0;
          end
        end
        RX_HDR: begin
          if (i_rx_stb) begin
            hdr_sr   <= {hdr_sr[75:0], i_rx_byte};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd11) begin
              o_data_count <= hdr_full[91:64];
              o_command    <= hdr_full[63:32];
              o_address    <= hdr_full[31:0];
              byte_cnt     <= '0;
              if (hdr_full[35:32] == 4'hF) begin
                rx_state <= RX_RST;
              end else if (hdr_full[35:32] == 4'h1) begin
                rx_state   <= RX_DATA;
                words_left <= (hdr_full[91:64] == 28'd0) ? 28'd1 : hdr_full[91:64];
              end else begin
                rx_state <= RX_PEND;
                o_data   <= '0;
              end
            end
          end else if (rx_timeout) begin
            rx_state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (i_rx_stb) begin
            data_sr  <= {data_sr[15:0], i_rx_byte};
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd3) begin
              o_data   <= {data_sr, i_rx_byte};
              byte_cnt <= '0;
              rx_state <= RX_PEND;
            end
          end else if (rx_timeout) begin
            rx_state <= RX_IDLE;
          end
        end
        RX_PEND: begin
          idle_cnt <= '0;
          if (i_rx_stb)
            o_rx_overflow <= 1'b1;
          if (i_master_ready && echo_ok) begin
            o_ready    <= 1'b1;
            words_left <= words_left - 28'd1;
            if (o_command[3:0] == 4'h1 && words_left != 28'd1)
              rx_state <= RX_DATA;
            else
              rx_state <= RX_IDLE;
          end
        end
        RX_RST: begin
          idle_cnt <= '0;
          if (i_rx_stb)
            o_rx_overflow <= 1'b1;
          o_ih_reset <= 1'b1;
          rx_state   <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state    <= TX_IDLE;
      tx_sr       <= '0;
      tx_left     <= '0;
      tx_gap      <= 1'b0;
      tx_is_echo  <= 1'b0;
      echo_done   <= 1'b0;
      o_out_ready <= 1'b1;
    end else begin
      tx_gap <= o_tx_stb;
      if (rx_state != RX_PEND)
        echo_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (i_en && o_out_ready) begin
            tx_sr       <= {SYNC_TX, i_status, 4'h0, i_data_count, i_address, i_data};
            tx_left     <= 5'd17;
            tx_is_echo  <= 1'b0;
            o_out_ready <= 1'b0;
            tx_state    <= TX_SEND;
          end else if (echo_req) begin
            tx_sr       <= {SYNC_TX, o_command, 96'h0};
            tx_left     <= 5'd5;
            tx_is_echo  <= 1'b1;
            o_out_ready <= 1'b0;
            tx_state    <= TX_SEND;
          end else begin
            o_out_ready <= 1'b1;
          end
        end
        TX_SEND: begin
          if (o_tx_stb) begin
            tx_sr   <= {tx_sr[127:0], 8'h00};
            tx_left <= tx_left - 5'd1;
            if (tx_left == 5'd1) begin
              tx_state <= TX_IDLE;
              // A pending echo keeps response capture closed until it has gone out.
              o_out_ready <= tx_is_echo || !echo_req;
              if (tx_is_echo)
                echo_done <= 1'b1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_byte_bridge.sv
// Randomized bench for host_byte_bridge: expected request words and TX bytes are kept in queues built from the frame rules.
module tb_host_byte_bridge;
  localparam logic [31:0] TMO = 32'd64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  i_rx_byte = 8'h00;
  logic        i_rx_stb = 1'b0;
  logic [7:0]  o_tx_byte;
  logic        o_tx_stb;
  logic        i_tx_busy = 1'b0;
  logic        i_master_ready = 1'b0;
  logic        o_ready;
  logic [31:0] o_command, o_address, o_data;
  logic [27:0] o_data_count;
  logic        o_ih_reset;
  logic        i_en = 1'b0;
  logic [31:0] i_status = 32'h0, i_address = 32'h0, i_data = 32'h0;
  logic [27:0] i_data_count = 28'h0;
  logic        o_out_ready;
  logic        o_rx_overflow;

  always #5 clk = ~clk;

  host_byte_bridge #(.RX_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .i_rx_byte(i_rx_byte), .i_rx_stb(i_rx_stb),
    .o_tx_byte(o_tx_byte), .o_tx_stb(o_tx_stb), .i_tx_busy(i_tx_busy),
    .i_master_ready(i_master_ready), .o_ready(o_ready), .o_command(o_command),
    .o_address(o_address), .o_data(o_data), .o_data_count(o_data_count),
    .o_ih_reset(o_ih_reset), .i_en(i_en), .i_status(i_status), .i_address(i_address),
    .i_data(i_data), .i_data_count(i_data_count), .o_out_ready(o_out_ready),
    .o_rx_overflow(o_rx_overflow)
  );

  int           n_checks = 0;
  int           n_fail = 0;
  int           ready_seen = 0;
  int           ihr_seen = 0;
  logic [123:0] word_q[$];
  logic [7:0]   tx_q[$];
  logic [31:0]  wbuf[8];
  bit           rand_ready = 1'b0;
  bit           ready_force = 1'b1;
  bit           prev_stb = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: every o_ready word and every TX strobe is matched against the model queues.
  always @(negedge clk) begin
    if (rst) begin
      if (o_ready) begin
        ready_seen++;
        if (word_q.size() == 0) check("ready_unexpected", o_ready, 0);
        else check("word", {o_command, o_address, o_data, o_data_count}, word_q.pop_front());
      end
      if (o_ih_reset) ihr_seen++;
      if (o_tx_stb) begin
        check("tx_busy", i_tx_busy, 0);
        check("tx_gap", prev_stb, 0);
        if (tx_q.size() == 0) check("tx_unexpected", o_tx_stb, 0);
        else check("tx_byte", o_tx_byte, tx_q.pop_front());
      end
    end
    prev_stb = o_tx_stb;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      i_master_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
      i_tx_busy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_byte = b;
    i_rx_stb = 1'b1;
    tick(1);
    i_rx_stb = 1'b0;
    tick(gap);
  endtask

  task automatic send32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], $urandom_range(0, 2));
  endtask

  task automatic push32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) tx_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic expect_word(input logic [31:0] cmd, input logic [31:0] addr,
                             input logic [31:0] data, input logic [27:0] cnt);
`ifdef HOST_BYTE_BRIDGE_ECHO_EN
    tx_q.push_back(8'hDC);
    push32(cmd);
`endif
    word_q.push_back({cmd, addr, data, cnt});
  endtask

  task automatic wait_ready(input int start, input string tag);
    int n;
    n = 0;
    while (ready_seen == start && n < 400) begin tick(1); n++; end
    check(tag, ready_seen, start + 1);
  endtask

  task automatic send_frame(input logic [31:0] cmd, input logic [31:0] addr, input logic [31:0] cnt);
    int nw, start, rst_start, n;
    logic [27:0] c28;
    c28 = cnt[27:0];
    nw = (c28 == 28'd0) ? 1 : int'(c28);
    if (cmd[3:0] == 4'h1)
      for (int i = 0; i < nw; i++) expect_word(cmd, addr, wbuf[i], c28);
    else if (cmd[3:0] != 4'hF)
      expect_word(cmd, addr, 32'h0, c28);
    send_byte(8'hCD, $urandom_range(0, 2));
    send32(cnt);
    send32(cmd);
    start = ready_seen;
    rst_start = ihr_seen;
    send32(addr);
    if (cmd[3:0] == 4'hF) begin
      n = 0;
      while (ihr_seen == rst_start && n < 50) begin tick(1); n++; end
      tick(3);
      check("ih_reset_pulse", ihr_seen, rst_start + 1);
      check("ih_reset_no_ready", ready_seen, start);
    end else if (cmd[3:0] == 4'h1) begin
      for (int i = 0; i < nw; i++) begin
        start = ready_seen;
        send32(wbuf[i]);
        wait_ready(start, "write_ready");
      end
    end else begin
      wait_ready(start, "read_ready");
    end
    tick(2);
  endtask

  task automatic send_resp(input logic [31:0] st, input logic [27:0] dc, input logic [31:0] ad,
                           input logic [31:0] da, input bit follow);
    int n;
    n = 0;
    while (!o_out_ready && n < 400) begin tick(1); n++; end
    check("resp_out_ready", o_out_ready, 1);
    tx_q.push_back(8'hDC);
    push32(st);
    push32({4'h0, dc});
    push32(ad);
    push32(da);
    i_en = 1'b1; i_status = st; i_data_count = dc; i_address = ad; i_data = da;
    tick(1);
    i_en = 1'b0; i_status = $urandom(); i_data_count = 28'($urandom()); i_address = $urandom(); i_data = $urandom();
    check("resp_capture_drop", o_out_ready, 0);
    tick(1);
    i_en = 1'b1;
    tick(1);
    i_en = 1'b0;
    if (follow) begin
      n = 0;
      while (tx_q.size() != 0 && n < 400) begin
        check("resp_out_ready_low", o_out_ready, 0);
        tick(1);
        n++;
      end
      check("resp_frame_done", tx_q.size(), 0);
      check("resp_out_ready_back", o_out_ready, 1);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flags"}, {o_ready, o_ih_reset, o_tx_stb, o_rx_overflow, o_out_ready}, 5'b00001);
    check({tag, "_fields"}, {o_command, o_address, o_data, o_data_count}, 124'h0);
    check({tag, "_tx_byte"}, o_tx_byte, 8'h00);
  endtask

  initial begin
    int start, kind, nw;
    logic [31:0] cmd, addr, cnt;

    tick(3);
    check_reset("reset");
    rst = 1'b1;
    tick(2);

    wbuf[0] = 32'hDEADBEEF;
    send_frame(32'h0000_0001, 32'h0100_0000, 32'h0000_0001);

    for (int i = 0; i < 3; i++) wbuf[i] = $urandom();
    send_frame(32'h5A5A_0001, $urandom(), 32'h0000_0003);

    // Read held off by the master; a stray byte during the stall must be dropped and flagged.
    ready_force = 1'b0;
    tick(2);
    addr = $urandom();
    cnt = 32'h7000_0010;
    expect_word(32'h0000_0002, addr, 32'h0, cnt[27:0]);
    start = ready_seen;
    send_byte(8'hCD, 0);
    send32(cnt);
    send32(32'h0000_0002);
    send32(addr);
    tick(20);
    check("stall_no_ready", ready_seen, start);
    check("stall_hold", {o_command, o_address, o_data, o_data_count}, {32'h2, addr, 32'h0, cnt[27:0]});
    check("overflow_clear", o_rx_overflow, 0);
    send_byte(8'h55, 1);
    check("overflow_set", o_rx_overflow, 1);
    ready_force = 1'b1;
    wait_ready(start, "stall_ready");
    tick(5);
    check("stall_single", ready_seen, start + 1);

    send_resp(32'hFFFF_FFFE, 28'd1, 32'h0, 32'h1234_5678, 1'b1);
    tick(40);

    // Header timeout: the partial frame is abandoned and the next one decodes cleanly.
    start = ready_seen;
    send_byte(8'hCD, 0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom()), 0);
    tick(int'(TMO) + 1);
    send_frame(32'h0000_0002, 32'hCAFE_0000, 32'h0000_0004);
    check("hdr_timeout_one_word", ready_seen, start + 1);

    // Data-phase timeout: nothing may be issued for the half-received word.
    start = ready_seen;
    send_byte(8'hCD, 0);
    send32(32'h0000_0001);
    send32(32'h0000_0001);
    send32(32'h1111_2222);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    tick(int'(TMO) + 1);
    check("data_timeout_no_ready", ready_seen, start);
    wbuf[0] = $urandom();
    send_frame(32'h0000_0001, 32'h3333_4444, 32'h0000_0001);

    cmd = $urandom();
    cmd[3:0] = 4'hF;
    send_frame(cmd, $urandom(), $urandom());

`ifndef HOST_BYTE_BRIDGE_ECHO_EN
    wbuf[0] = $urandom();
    wbuf[1] = $urandom();
    fork
      send_frame(32'h0000_0011, 32'h0000_8000, 32'h0000_0002);
      send_resp($urandom(), 28'($urandom()), $urandom(), $urandom(), 1'b1);
    join
`endif

    rand_ready = 1'b1;
    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 3);
      cmd = $urandom();
      addr = $urandom();
      cnt = $urandom();
      case (kind)
        0: begin
          nw = $urandom_range(1, 3);
          cmd[3:0] = 4'h1;
          cnt[27:0] = 28'(nw);
          if (nw == 1 && $urandom_range(0, 1) == 1) cnt[27:0] = 28'd0;
          for (int i = 0; i < nw; i++) wbuf[i] = $urandom();
          send_frame(cmd, addr, cnt);
        end
        1: begin
          cmd[3:0] = 4'($urandom_range(2, 14));
          send_frame(cmd, addr, cnt);
        end
        2: send_resp($urandom(), 28'($urandom()), $urandom(), $urandom(), 1'b1);
        default: begin
          cmd[3:0] = 4'hF;
          send_frame(cmd, addr, cnt);
        end
      endcase
    end
    rand_ready = 1'b0;
    ready_force = 1'b1;
    tick(10);

    // Reset in the middle of a request header and a response frame.
    check("overflow_sticky", o_rx_overflow, 1);
    send_byte(8'hCD, 0);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom()), 0);
    send_resp(32'hA1B2_C3D4, 28'd9, 32'h5, 32'h6, 1'b0);
    tick(4);
    rst = 1'b0;
    tick(2);
    check_reset("mid_reset");
    tx_q.delete();
    rst = 1'b1;
    tick(2);
    wbuf[0] = 32'h0BAD_F00D;
    wbuf[1] = 32'h1234_ABCD;
    send_frame(32'h0000_0001, 32'h0000_0040, 32'h0000_0002);
    send_resp(32'h0000_0000, 28'hFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b1);

    tick(20);
    check("words_left", word_q.size(), 0);
    check("tx_left", tx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/host_byte_bridge.md
Name: host_byte_bridge

Overview:
- Host-side counterpart of `wishbone_master`'s host interface, driving the other end of that interface.
- Parses an incoming byte stream into command packets and drives `wishbone_master`'s in_ready, in_command, in_address, in_data, in_data_count and ih_reset inputs.
- Captures each out_en response word and serializes it back out as a byte frame.
- Sits between a UART/FTDI byte PHY and `wishbone_master` in every host-connected image.

Parameters:
- RX_TIMEOUT, 32'd100000: idle cycles allowed mid-packet before the RX FSM aborts back to IDLE.
- SYNC_RX, 8'hCD: request frame sync byte.
- SYNC_TX, 8'hDC: response frame sync byte.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- i_rx_byte  in  8  received byte
- i_rx_stb  in  1  i_rx_byte valid, one cycle per byte
- o_tx_byte  out  8  byte to transmit
- o_tx_stb  out  1  one-cycle transmit strobe
- i_tx_busy  in  1  PHY busy; o_tx_stb must not assert while high
- i_master_ready  in  1  master can accept a word
- o_ready  out  1  one-cycle word strobe to master (in_ready)
- o_command  out  32  to in_command
- o_address  out  32  to in_address
- o_data  out  32  to in_data
- o_data_count  out  28  to in_data_count
- o_ih_reset  out  1  one-cycle interface reset pulse
- i_en  in  1  master response word valid (out_en)
- i_status  in  32  response status
- i_address  in  32  response address
- i_data  in  32  response data
- i_data_count  in  28  response data count
- o_out_ready  out  1  bridge can accept a response word
- o_rx_overflow  out  1  sticky: a byte arrived while a word was pending

Behaviour:
- Reset (rst==0 at a clk edge):
  - o_ready, o_ih_reset, o_tx_stb, o_rx_overflow = 0.
  - All data outputs = 0.
  - o_out_ready = 1.
  - Both FSMs go to IDLE. Reset mid-packet or mid-frame discards all partial state.
- Byte order: big-endian, MSB byte first, for every 32-bit field.
- RX frame: SYNC_RX, data_count[4], command[4], address[4], then data words.
  - data_count bits [31:28] are discarded.
  - Write command: command[3:0]==4'h1. Number of data words N = (data_count==0) ? 1 : data_count.
  - Reset command: command[3:0]==4'hF.
  - All other commands: read/control.
- RX FSM states IDLE, HDR, DATA, PEND, RST:
  - IDLE: non-sync bytes are ignored; SYNC_RX moves to HDR with the byte counter cleared.
  - HDR: collects 12 bytes. On the 12th byte:
    - reset command -> RST;
    - write -> DATA;
    - otherwise -> PEND with o_data=0.
  - RST: o_ih_reset high for exactly 1 cycle, then IDLE. o_ready is never asserted.
  - DATA: collects 4 bytes into o_data, then -> PEND.
  - PEND: outputs held stable. o_ready pulses for 1 cycle on the first cycle i_master_ready==1. Then:
    - write with words remaining -> DATA;
    - otherwise -> IDLE.
    - Every word, first included, carries the same command/address/count.
  - i_rx_stb while in PEND or RST: byte dropped, o_rx_overflow set (cleared only by reset).
- RX timeout: in HDR or DATA, a counter clears on each i_rx_stb. At RX_TIMEOUT idle cycles the FSM returns to IDLE and nothing is issued. The counter saturates and never wraps.
- TX frame: SYNC_TX, status[4], data_count[4] (zero-extended), address[4], data[4] = 17 bytes.
- TX FSM states IDLE, SEND:
  - IDLE: when i_en && o_out_ready, capture all i_* response fields, drop o_out_ready on the next cycle, -> SEND.
  - SEND: emit one byte per o_tx_stb, only on cycles with i_tx_busy==0, with at most one strobe every 2 cycles so the PHY can raise busy.
  - After the 17th byte: o_out_ready=1, -> IDLE.
  - i_en while o_out_ready==0 is ignored; the master must hold the word until o_out_ready.
- RX and TX run independently. A response may serialize while a request is being parsed.

Optional Feature:
- HOST_BYTE_BRIDGE_ECHO_EN defined: in PEND, the 4-byte command word is echoed as a 5-byte TX frame (SYNC_TX, command[4]) before o_ready is issued.
  - If the TX FSM is busy, the echo waits until it is idle.
  - An echo request blocks response capture (o_out_ready held 0) until the echo completes.
- Undefined: no echo; o_ready is issued as above.

Test Plan:
- Write 1 word:
  - Stimulus: CD 00000001 00000001 01000000 DEADBEEF, i_master_ready=1.
  - Response: one o_ready pulse with command=1, address=01000000, data=DEADBEEF, count=1.
- Write 3 words (count=3): three o_ready pulses carrying data words in order; command and address are identical on each.
- Read with stall:
  - Stimulus: read frame (command=2) with i_master_ready=0 for 20 cycles.
  - Response: outputs held stable, no o_ready until ready rises, then exactly 1 pulse with o_data=0.
  - A byte injected during the stall sets o_rx_overflow=1.
- Response frame:
  - Stimulus: i_en with status=FFFFFFFE, count=1, address=0, data=12345678; i_tx_busy toggling.
  - Response: exactly 17 bytes DC FF FF FF FE 00 00 00 01 00 00 00 00 12 34 56 78, none strobed while busy; o_out_ready low until the last byte.
- Timeout and reset: send CD plus 5 bytes, then idle for RX_TIMEOUT+1 cycles; the next full frame decodes correctly. A reset-command frame yields a single o_ih_reset pulse and no o_ready. rst=0 mid-frame returns all outputs to their reset values.
- ECHO_EN build: each issued word is preceded by the TX bytes DC followed by the command bytes; the response frame follows after the echo.
